perceptron_trainer: RTL and testbench



---
 rtl/perceptron_pkg.sv | 31 +++
 rtl/perceptron_trainer_fp16_fma.sv | 82 ++++++++
 rtl/perceptron_trainer.sv | 157 +++++++++++++++
 tb/tb_perceptron_trainer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared fp16 constants, trainer state encoding and fp16 helpers
package perceptron_pkg;

    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SUM,
        CLASSIFY,
        UPDATE,
        EPOCH_END,
        DONE
    } state_t;

    function automatic logic [FP16_W-1:0] fp16_neg(input logic [FP16_W-1:0] v);
        return {~v[15], v[14:0]};
    endfunction

    function automatic logic fp16_is_zero(input logic [FP16_W-1:0] v);
        return (v[14:0] == 15'd0);
    endfunction

    function automatic logic fp16_is_nan(input logic [FP16_W-1:0] v);
        return (v[14:10] == 5'h1f) && (v[9:0] != 10'd0);
    endfunction

endpackage

// File: rtl/perceptron_trainer_fp16_fma.sv
// rtl/perceptron_trainer_fp16_fma.sv - combinational fp16 a*b+c, single RNE rounding, flush-to-zero
module fp16_fma
    import perceptron_pkg::*;
(
    input  logic [FP16_W-1:0] a,
    input  logic [FP16_W-1:0] b,
    input  logic [FP16_W-1:0] c,
    output logic [FP16_W-1:0] y
);
    // Exact fixed-point sum, LSB weight 2^-48: holds every normal product and addend without loss
    localparam int FW = 81;

    logic a_zero, b_zero, c_zero, a_inf, b_inf, c_inf, any_nan, sp, sum_sign, rnd;
    logic [21:0] mp;
    logic [6:0] sh_p, sh_c, lead;
    logic [FW-1:0] pf, cf, sum, norm;
    logic [11:0] mr;
    logic signed [7:0] exp_r;
    logic [9:0] mant;

    always_comb begin
        a_zero  = (a[14:10] == 5'd0);
        b_zero  = (b[14:10] == 5'd0);
        c_zero  = (c[14:10] == 5'd0);
        a_inf   = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
        b_inf   = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
        c_inf   = (c[14:10] == 5'h1f) && (c[9:0] == 10'd0);
        any_nan = fp16_is_nan(a) || fp16_is_nan(b) || fp16_is_nan(c);
        sp      = a[15] ^ b[15];

        mp   = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        sh_p = 7'(a[14:10]) + 7'(b[14:10]) - 7'd2;
        sh_c = 7'(c[14:10]) + 7'd23;
        pf   = FW'(mp) << sh_p;
        cf   = c_zero ? '0 : (FW'({1'b1, c[9:0]}) << sh_c);

        if (sp == c[15]) begin
            sum      = pf + cf;
            sum_sign = sp;
        end else if (pf >= cf) begin
            sum      = pf - cf;
            sum_sign = sp;
        end else begin
            sum      = cf - pf;
            sum_sign = c[15];
        end

        lead = '0;
        for (int i = 0; i < FW; i++) begin
            if (sum[i]) lead = 7'(i);
        end
        norm  = sum << (7'(FW - 1) - lead);
        rnd   = norm[69] & (norm[70] | (|norm[68:0]));
        mr    = {1'b0, norm[80:70]} + 12'(rnd);
        exp_r = $signed({1'b0, lead}) - 8'sd33;
        mant  = mr[9:0];
        if (mr[11]) begin
            exp_r = exp_r + 8'sd1;
            mant  = mr[10:1];
        end

        if (any_nan || ((a_inf || b_inf) && (a_zero || b_zero))
                || ((a_inf || b_inf) && c_inf && (sp != c[15]))) begin
            y = FP16_QNAN;
        end else if (a_inf || b_inf) begin
            y = {sp, 5'h1f, 10'd0};
        end else if (c_inf) begin
            y = {c[15], 5'h1f, 10'd0};
        end else if (a_zero || b_zero) begin
            y = c_zero ? {sp & c[15], 15'd0} : c;
        end else if (sum == '0) begin
            y = FP16_ZERO;
        end else if (exp_r <= 8'sd0) begin
            y = {sum_sign, 15'd0};
        end else if (exp_r >= 8'sd31) begin
            y = {sum_sign, 5'h1f, 10'd0};
        end else begin
            y = {sum_sign, exp_r[4:0], mant};
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - multi-epoch fp16 perceptron trainer with start/busy/done handshake
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int N_IN       = 2,
    parameter int N_SAMP     = 4,
    parameter int MAX_EPOCHS = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [N_SAMP*N_IN*FP16_W-1:0]      x,
    input  logic [N_SAMP*FP16_W-1:0]           d,
    input  logic [FP16_W-1:0]                  u,
    input  logic [(N_IN+1)*FP16_W-1:0]         w_init,
    output logic [(N_IN+1)*FP16_W-1:0]         w_out,
    output logic [N_SAMP*FP16_W-1:0]           result,
    output logic                               busy,
    output logic                               done,
    output logic                               converged,
    output logic [$clog2(MAX_EPOCHS+1)-1:0]    epochs_used
);
    localparam int KW = $clog2(N_IN + 2);
    localparam int SW = $clog2(N_SAMP + 1);
    localparam int EW = $clog2(MAX_EPOCHS + 1);

    state_t state_q, state_d;
    logic start_q;
    logic [N_SAMP*N_IN*FP16_W-1:0] x_q;
    logic [N_SAMP*FP16_W-1:0] d_q, result_q;
    logic [FP16_W-1:0] u_q, acc_q;
    logic [(N_IN+1)*FP16_W-1:0] w_q;
    logic [KW-1:0] k_q;
    logic [SW-1:0] s_q, err_q;
    logic [EW-1:0] ep_q;
    logic conv_q;

    logic last_k, last_s, target_one, y_one, mismatch;
    logic [FP16_W-1:0] x_k, w_k, eu, fma_a, fma_b, fma_c, fma_y;

    always_comb begin
        last_k     = (k_q == KW'(N_IN));
        last_s     = (s_q == SW'(N_SAMP - 1));
        target_one = !fp16_is_zero(d_q[int'(s_q)*FP16_W +: FP16_W]);
        y_one      = fp16_is_zero(acc_q) || (!acc_q[15] && !fp16_is_nan(acc_q));
        mismatch   = (y_one != target_one);
        eu         = target_one ? u_q : fp16_neg(u_q);
        w_k        = w_q[int'(k_q)*FP16_W +: FP16_W];
        // Input 0 is the implicit bias input of 1.0
        if (k_q == '0) x_k = FP16_ONE;
        else           x_k = x_q[(int'(s_q)*N_IN + int'(k_q) - 1)*FP16_W +: FP16_W];
        if (state_q == UPDATE) begin
            fma_a = eu;
            fma_b = x_k;
            fma_c = w_k;
        end else begin
            fma_a = w_k;
            fma_b = x_k;
            fma_c = acc_q;
        end
    end

    fp16_fma u_fma (
        .a (fma_a),
        .b (fma_b),
        .c (fma_c),
        .y (fma_y)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_q) state_d = LOAD;
            LOAD:      state_d = SUM;
            SUM:       if (last_k) state_d = CLASSIFY;
            CLASSIFY: begin
                if (mismatch)    state_d = UPDATE;
                else if (last_s) state_d = EPOCH_END;
                else             state_d = SUM;
            end
            UPDATE:    if (last_k) state_d = last_s ? EPOCH_END : SUM;
            EPOCH_END: begin
                if (err_q == '0 || ep_q == EW'(MAX_EPOCHS - 1)) state_d = DONE;
                else                                            state_d = SUM;
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q  <= 1'b0;
            x_q      <= '0;
            d_q      <= '0;
            u_q      <= '0;
            w_q      <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            s_q      <= '0;
            err_q    <= '0;
            ep_q     <= '0;
            conv_q   <= 1'b0;
            result_q <= '0;
        end else begin
            // start is registered while idle; LOAD begins on the following edge
            start_q <= (state_q == IDLE) && start && !start_q;
            case (state_q)
                LOAD: begin
                    x_q    <= x;
                    d_q    <= d;
                    u_q    <= u;
                    w_q    <= w_init;
                    ep_q   <= '0;
                    conv_q <= 1'b0;
                    k_q    <= '0;
                    s_q    <= '0;
                    err_q  <= '0;
                end
                SUM: begin
                    acc_q <= (k_q == '0) ? w_k : fma_y;
                    k_q   <= last_k ? '0 : k_q + KW'(1);
                end
                CLASSIFY: begin
                    result_q[int'(s_q)*FP16_W +: FP16_W] <= y_one ? FP16_ONE : FP16_ZERO;
                    if (mismatch)     err_q <= err_q + SW'(1);
                    else if (!last_s) s_q   <= s_q + SW'(1);
                end
                UPDATE: begin
                    w_q[int'(k_q)*FP16_W +: FP16_W] <= fma_y;
                    k_q <= last_k ? '0 : k_q + KW'(1);
                    if (last_k && !last_s) s_q <= s_q + SW'(1);
                end
                EPOCH_END: begin
                    ep_q  <= ep_q + EW'(1);
                    if (err_q == '0) conv_q <= 1'b1;
                    s_q   <= '0;
                    err_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign w_out       = w_q;
    assign result      = result_q;
    assign converged   = conv_q;
    assign epochs_used = ep_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - table-driven directed checks for perceptron_trainer
module tb_perceptron_trainer;
    localparam int N_IN       = 2;
    localparam int N_SAMP     = 4;
    localparam int MAX_EPOCHS = 16;
    localparam int EW         = $clog2(MAX_EPOCHS + 1);
    localparam int XW         = N_SAMP * N_IN * 16;
    localparam int DW         = N_SAMP * 16;
    localparam int WW         = (N_IN + 1) * 16;
    localparam int NV         = 6;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [XW-1:0] x;
    logic [DW-1:0] d;
    logic [15:0]   u;
    logic [WW-1:0] w_init, w_out;
    logic [DW-1:0] result;
    logic          busy, done, converged;
    logic [EW-1:0] epochs_used;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    perceptron_trainer #(.N_IN(N_IN), .N_SAMP(N_SAMP), .MAX_EPOCHS(MAX_EPOCHS)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .x           (x),
        .d           (d),
        .u           (u),
        .w_init      (w_init),
        .w_out       (w_out),
        .result      (result),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .epochs_used (epochs_used)
    );

    typedef struct {
        string         name;
        logic [XW-1:0] x;
        logic [DW-1:0] d;
        logic [15:0]   u;
        logic [WW-1:0] w_init;
        logic          conv;
        int            epochs;
        bit            chk_w;
        logic [WW-1:0] w;
        bit            chk_r;
        logic [DW-1:0] res;
        int            cycles;
    } vec_t;

    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        int n;
        bit seen;
        @(negedge clk);
        x      = vecs[i].x;
        d      = vecs[i].d;
        u      = vecs[i].u;
        w_init = vecs[i].w_init;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({vecs[i].name, " busy_after_edge0"}, 64'(busy), 64'(0));
        n    = 0;
        seen = 1'b0;
        while (n < 3000 && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) check({vecs[i].name, " busy_after_edge1"}, 64'(busy), 64'(1));
            if (done) seen = 1'b1;
        end
        check({vecs[i].name, " done_seen"}, 64'(seen), 64'(1));
        if (vecs[i].cycles != 0) check({vecs[i].name, " done_edge"}, 64'(n), 64'(vecs[i].cycles));
        check({vecs[i].name, " busy_at_done"}, 64'(busy), 64'(0));
        check({vecs[i].name, " converged"}, 64'(converged), 64'(vecs[i].conv));
        check({vecs[i].name, " epochs_used"}, 64'(epochs_used), 64'(vecs[i].epochs));
        if (vecs[i].chk_w) check({vecs[i].name, " w_out"}, 64'(w_out), 64'(vecs[i].w));
        if (vecs[i].chk_r) check({vecs[i].name, " result"}, 64'(result), 64'(vecs[i].res));
        @(negedge clk);
        check({vecs[i].name, " done_one_cycle"}, 64'(done), 64'(0));
        check({vecs[i].name, " busy_after_done"}, 64'(busy), 64'(0));
        check({vecs[i].name, " epochs_hold"}, 64'(epochs_used), 64'(vecs[i].epochs));
    endtask

    initial begin
        logic [XW-1:0] and_x, zero_x;
        int dn, bz;
        and_x  = {16'h3C00, 16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 16'h3C00, 16'h0000, 16'h0000};
        zero_x = '0;
        // name, x, d, u, w_init, conv, epochs, chk_w, w, chk_r, result, done edge
        vecs[0] = '{"and", and_x, {16'h3C00, 16'h0000, 16'h0000, 16'h0000}, 16'h3800,
                    {16'h3C00, 16'h3C00, 16'h3C00}, 1'b1, 6, 1'b1, {16'h3C00, 16'h3800, 16'hBE00},
                    1'b1, {16'h3C00, 16'h0000, 16'h0000, 16'h0000}, 137};
        vecs[1] = '{"xor", and_x, {16'h0000, 16'h3C00, 16'h3C00, 16'h0000}, 16'h3800,
                    {16'h3C00, 16'h3C00, 16'h3C00}, 1'b0, 16, 1'b0, '0, 1'b0, '0, 0};
        vecs[2] = '{"u_zero", and_x, {16'h3C00, 16'h0000, 16'h0000, 16'h0000}, 16'h0000,
                    {16'h3C00, 16'h3C00, 16'h3C00}, 1'b0, 16, 1'b1, {16'h3C00, 16'h3C00, 16'h3C00},
                    1'b1, {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}, 418};
        vecs[3] = '{"nan_bias", and_x, '0, 16'h3800,
                    {16'h3C00, 16'h3C00, 16'h7E00}, 1'b1, 1, 1'b1, {16'h3C00, 16'h3C00, 16'h7E00},
                    1'b1, '0, 19};
        vecs[4] = '{"neg_zero", zero_x, {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}, 16'h3800,
                    {16'h8000, 16'h8000, 16'h8000}, 1'b1, 1, 1'b1, {16'h8000, 16'h8000, 16'h8000},
                    1'b1, {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}, 19};
        vecs[5] = '{"or", and_x, {16'h3C00, 16'h3C00, 16'h3C00, 16'h0000}, 16'h3800,
                    '0, 1'b1, 4, 1'b1, {16'h3800, 16'h3800, 16'hB800},
                    1'b1, {16'h3C00, 16'h3C00, 16'h3C00, 16'h0000}, 85};

        reset  = 1'b1;
        start  = 1'b0;
        x      = '0;
        d      = '0;
        u      = '0;
        w_init = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset w_out", 64'(w_out), 64'(0));
        check("reset result", 64'(result), 64'(0));
        check("reset epochs_used", 64'(epochs_used), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Abort: a re-pulsed start while busy must not restart after a mid-epoch reset
        dn = 0;
        @(negedge clk);
        x      = vecs[0].x;
        d      = vecs[0].d;
        u      = vecs[0].u;
        w_init = vecs[0].w_init;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort busy_before_reset", 64'(busy), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        check("abort w_out", 64'(w_out), 64'(0));
        check("abort result", 64'(result), 64'(0));
        check("abort converged", 64'(converged), 64'(0));
        check("abort epochs_used", 64'(epochs_used), 64'(0));
        bz = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) dn++;
            if (busy) bz++;
        end
        check("abort done_pulses", 64'(dn), 64'(0));
        check("abort busy_cycles", 64'(bz), 64'(0));

        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
